// File: rtl/dense_mac_engine.sv
// dense_mac_engine: one-MAC-per-cycle dense layer with selectable activation.
// Define DENSE_SAT_EN to saturate the scaled sum instead of wrapping it.
module dense_mac_engine #(
  parameter int    NB_INPUT    = 42,
  parameter int    NB_NEURONS  = 24,
  parameter int    FIXED       = 32,
  parameter int    FRAC        = 16,
  parameter int    WSHIFT      = 8,
  parameter string WEIGHT_FILE = "weights_fixed.mem",
  parameter string BIAS_FILE   = "bias_fixed.mem"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   act_sel,
  input  logic [NB_INPUT*FIXED-1:0]    in_vec,
  output logic                         busy,
  output logic                         done,
  output logic [NB_NEURONS*FIXED-1:0]  out_vec
);

  localparam int IW = (NB_INPUT > 1) ? $clog2(NB_INPUT) : 1;
  localparam int NW = (NB_NEURONS > 1) ? $clog2(NB_NEURONS) : 1;
  localparam int WD = NB_INPUT * NB_NEURONS;
  localparam int WA = (WD > 1) ? $clog2(WD) : 1;
  localparam int AW = 2 * FIXED + $clog2(NB_INPUT) + 1;
  localparam int PW = FIXED + 2;
  localparam logic [IW-1:0] LAST_I = IW'(NB_INPUT - 1);
  localparam logic [NW-1:0] LAST_N = NW'(NB_NEURONS - 1);
  localparam logic signed [PW-1:0] ONE  = PW'(1) <<< FRAC;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] NONE = -ONE;

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_e;
  state_e state_q, state_d;

  logic signed [FIXED-1:0] w_mem [WD];
  logic signed [FIXED-1:0] b_mem [NB_NEURONS];

  logic signed [FIXED-1:0]   x_q [NB_INPUT];
  logic signed [FIXED-1:0]   y_q [NB_NEURONS];
  logic [1:0]                act_q;
  logic [IW-1:0]             i_q;
  logic [NW-1:0]             n_q, n_nxt;
  logic signed [AW-1:0]      acc_q;
  logic [WA-1:0]             waddr;
  logic signed [2*FIXED-1:0] prod;
  logic signed [AW-1:0]      bias_ext;
  logic signed [FIXED-1:0]   rf, y_d;
  logic signed [PW-1:0]      rx, hs;

  assign waddr    = WA'(int'(i_q) * NB_NEURONS + int'(n_q));
  assign prod     = x_q[i_q] * w_mem[waddr];
  assign n_nxt    = (state_q == ACT && n_q != LAST_N) ? n_q + 1'b1 : '0;
  assign bias_ext = AW'(b_mem[n_nxt]) <<< FRAC;

`ifdef DENSE_SAT_EN
  localparam logic signed [AW-1:0] RMAX =
    {{(AW-FIXED+1){1'b0}}, {(FIXED-1){1'b1}}};
  localparam logic signed [AW-1:0] RMIN = ~RMAX;
  logic signed [AW-1:0] r;
  assign r  = acc_q >>> (FRAC + WSHIFT);
  assign rf = (r > RMAX) ? {1'b0, {(FIXED-1){1'b1}}} :
              (r < RMIN) ? {1'b1, {(FIXED-1){1'b0}}} :
              r[FIXED-1:0];
`else
  assign rf = acc_q[FRAC+WSHIFT +: FIXED];
`endif

  assign rx = PW'(rf);
  assign hs = (rx >>> 2) + HALF;

  always_comb begin
    y_d = rf;
    unique case (act_q)
      2'd0: y_d = rf;
      2'd1: y_d = rf[FIXED-1] ? '0 : rf;
      2'd2: begin
        if (rx > ONE)       y_d = ONE[FIXED-1:0];
        else if (rx < NONE) y_d = NONE[FIXED-1:0];
      end
      2'd3: begin
        if (hs < 0)        y_d = '0;
        else if (hs > ONE) y_d = ONE[FIXED-1:0];
        else               y_d = hs[FIXED-1:0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = MAC;
      MAC:  if (i_q == LAST_I) state_d = ACT;
      ACT:  state_d = (n_q == LAST_N) ? DONE : MAC;
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < NB_INPUT; k++) x_q[k] <= '0;
      for (int k = 0; k < NB_NEURONS; k++) y_q[k] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          act_q <= act_sel;
          for (int k = 0; k < NB_INPUT; k++)
            x_q[k] <= in_vec[k*FIXED +: FIXED];
          i_q   <= '0;
          n_q   <= '0;
          acc_q <= bias_ext;
        end
        MAC: begin
          acc_q <= acc_q + AW'(prod);
          i_q   <= (i_q == LAST_I) ? '0 : i_q + 1'b1;
        end
        ACT: begin
          y_q[n_q] <= y_d;
          n_q      <= n_nxt;
          acc_q    <= bias_ext;
        end
        DONE: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  for (genvar g = 0; g < NB_NEURONS; g++) begin : g_out
    assign out_vec[g*FIXED +: FIXED] = y_q[g];
  end

endmodule
